step_controller: RTL

- Board-input front end for the datapath, in the opposite direction to the PC display: it reads push-buttons and switches and produces a one-cycle advance enable `step_en` for the processor.
- Supports three things:
  - single-step on a key press;
  - free-run toggled by a second key;
  - a switch-selected breakpoint on the instruction index PC/4, which is the same index the 7-segment display shows.
- Sits between the board I/O pins and the datapath's PC-register enable.

---
 rtl/step_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/step_controller.sv
// Board-input front end: conditions the step/run push-buttons and turns them,
// together with a switch-selected instruction-index breakpoint, into the
// one-cycle PC advance enable for the datapath.
module step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        KEY_STEP,
  input  logic        KEY_RUN,
  input  logic [6:0]  SW_BP,
  input  logic        SW_BP_EN,
  input  logic [31:0] PC,
  output logic        step_en,
  output logic        running,
  output logic        bp_hit
);

  localparam int unsigned NUM_KEYS = 2;
  localparam int unsigned KEY_STEP_IDX = 0;
  localparam int unsigned KEY_RUN_IDX  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]  BP_INDEX_MAX = 7'd99;
  localparam logic [31:0] PC_WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    S_PAUSE  = 3'd0,
    S_STEP   = 3'd1,
    S_RUN    = 3'd2,
    S_BREAK  = 3'd3,
    S_RESUME = 3'd4
  } state_t;

  state_t state;

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] press;
  logic                step_ev;
  logic                run_ev;
  logic                bp_match;

  assign key_raw = {KEY_RUN, KEY_STEP};

  // Per-key two-flop synchronizer, debounce counter and press-event flop.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic             sync_a;
    logic             sync_b;
    logic             db_level;
    logic             press_q;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous key level into the clk domain.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_a <= 1'b1;
        sync_b <= 1'b1;
      end else begin
        sync_a <= key_raw[k];
        sync_b <= sync_a;
      end
    end

    // Accept a level change only after it has been stable long enough;
    // a press event fires for exactly one cycle on an accepted 1->0 change.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        db_level <= 1'b1;
        cnt      <= '0;
        press_q  <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (sync_b == db_level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          db_level <= sync_b;
          cnt      <= '0;
          press_q  <= ~sync_b;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign press[k] = press_q;
  end

  assign step_ev = press[KEY_STEP_IDX];
  assign run_ev  = press[KEY_RUN_IDX];

  // Breakpoint on the instruction index PC/4; byte offset bits are masked off.
  assign bp_match = SW_BP_EN && (SW_BP <= BP_INDEX_MAX) &&
                    ((PC & PC_WORD_MASK) == {23'b0, SW_BP, 2'b00});

  // Control state machine, one transition per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_PAUSE;
    end else begin
      case (state)
        S_PAUSE: begin
          if (run_ev) begin
            state <= S_RUN;
          end else if (step_ev) begin
            state <= S_STEP;
          end
        end
        S_STEP: begin
          state <= S_PAUSE;
        end
        S_RUN: begin
          if (run_ev) begin
            state <= S_PAUSE;
          end else if (bp_match) begin
            state <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (run_ev) begin
            state <= S_RESUME;
          end else if (step_ev) begin
            state <= S_STEP;
          end
        end
        S_RESUME: begin
          state <= S_RUN;
        end
        default: begin
          state <= S_PAUSE;
        end
      endcase
    end
  end

  // Advance enable: the RUN term drops in the cycle the machine leaves RUN so
  // the PC holds exactly on the breakpoint address.
  always_comb begin
    step_en = 1'b0;
    case (state)
      S_STEP:   step_en = 1'b1;
      S_RESUME: step_en = 1'b1;
      S_RUN:    step_en = ~(run_ev | bp_match);
      default:  step_en = 1'b0;
    endcase
  end

  // Status outputs decoded straight from the state register.
  assign running = (state == S_RUN) || (state == S_RESUME);
  assign bp_hit  = (state == S_BREAK);

endmodule
